// File: rtl/ps2_tarama_alici.sv
// PS/2 Set-2 keyboard receiver: synchronises and filters the pins, frames and
// parity-checks bytes, then steers make codes onto the button or control channel.
module ps2_tarama_alici #(
  parameter int FILTRE      = 4,
  parameter int ZAMAN_ASIMI = 100000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] buton_giris,
  output logic       buton_aktif,
  output logic [7:0] kontrol_giris,
  output logic       kontrol_aktif,
  output logic       cerceve_hata
);

  localparam int FW = (FILTRE > 1) ? $clog2(FILTRE) : 1;
  localparam int TW = (ZAMAN_ASIMI > 2) ? $clog2(ZAMAN_ASIMI) : 1;

  typedef enum logic [1:0] {BOSTA, VERI, PARITE, DUR} cerceve_t;
  typedef enum logic [2:0] {NORMAL, UZATMA, BIRAK, UZATMA_BIRAK, DURAKLAT} kod_t;

  logic [1:0]    clk_s, dat_s;
  logic          sclk, sdat, filt;
  logic [FW-1:0] fcnt;
  logic          bit_edge;

  cerceve_t      c_st, c_nxt;
  logic [2:0]    bit_cnt, bit_nxt;
  logic [7:0]    shreg, sh_nxt;
  logic          par, par_nxt;
  logic [TW-1:0] idle, idle_nxt;
  logic          bayt_iyi, hata_nxt;

  kod_t          d_st, d_nxt;
  logic [2:0]    skip, skip_nxt;
  logic          emit_but, emit_kon;

  function automatic logic kontrol_mu(input logic [7:0] b);
    case (b)
      8'h58, 8'h12, 8'h59, 8'h77, 8'h29, 8'h76, 8'h05, 8'h06,
      8'h04, 8'h0C, 8'h03, 8'h0B, 8'h83, 8'h0A, 8'h01, 8'h09,
      8'h78, 8'h07, 8'h0D, 8'h14, 8'h11, 8'h66, 8'h5A: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic dusur_mu(input logic [7:0] b);
    case (b)
      8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFE, 8'hFF: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  assign sclk = clk_s[1];
  assign sdat = dat_s[1];

  // Synchronisers idle high so reset never fabricates a falling edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_s <= '1;
      dat_s <= '1;
      filt  <= 1'b1;
      fcnt  <= '0;
    end else begin
      clk_s <= {clk_s[0], ps2_clk};
      dat_s <= {dat_s[0], ps2_data};
      if (sclk == filt) begin
        fcnt <= '0;
      end else if (fcnt == FW'(FILTRE - 1)) begin
        filt <= sclk;
        fcnt <= '0;
      end else begin
        fcnt <= fcnt + FW'(1);
      end
    end
  end

  // The edge fires in the cycle the new low level completes FILTRE cycles.
  assign bit_edge = (sclk != filt) && (fcnt == FW'(FILTRE - 1)) && !sclk;

  always_comb begin
    c_nxt    = c_st;
    bit_nxt  = bit_cnt;
    sh_nxt   = shreg;
    par_nxt  = par;
    bayt_iyi = 1'b0;
    hata_nxt = 1'b0;
    idle_nxt = (c_st == BOSTA) ? '0 : idle + TW'(1);
    if (bit_edge) begin
      idle_nxt = '0;
      case (c_st)
        BOSTA: if (!sdat) begin
          c_nxt   = VERI;
          bit_nxt = '0;
        end
        VERI: begin
          sh_nxt  = {sdat, shreg[7:1]};
          bit_nxt = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) c_nxt = PARITE;
        end
        PARITE: begin
          par_nxt = sdat;
          c_nxt   = DUR;
        end
        DUR: begin
          if (sdat && (^{shreg, par})) bayt_iyi = 1'b1;
          else                         hata_nxt = 1'b1;
          c_nxt = BOSTA;
        end
        default: c_nxt = BOSTA;
      endcase
    end else if (c_st != BOSTA && idle_nxt == TW'(ZAMAN_ASIMI - 1)) begin
      c_nxt    = BOSTA;
      hata_nxt = 1'b1;
      idle_nxt = '0;
    end
  end

  always_comb begin
    d_nxt    = d_st;
    skip_nxt = skip;
    emit_but = 1'b0;
    emit_kon = 1'b0;
    if (bayt_iyi) begin
      case (d_st)
        NORMAL: begin
          if (shreg == 8'hE0) d_nxt = UZATMA;
          else if (shreg == 8'hF0) d_nxt = BIRAK;
          else if (shreg == 8'hE1) begin
            d_nxt    = DURAKLAT;
            skip_nxt = 3'd7;
          end else if (!dusur_mu(shreg)) begin
            emit_kon = kontrol_mu(shreg);
            emit_but = !kontrol_mu(shreg);
          end
        end
        UZATMA: begin
          d_nxt = NORMAL;
          if (shreg == 8'hF0) d_nxt = UZATMA_BIRAK;
          else if (shreg == 8'h5A || shreg == 8'h14 || shreg == 8'h11) emit_kon = 1'b1;
          else if (shreg == 8'h4A) emit_but = 1'b1;
        end
        DURAKLAT: begin
          skip_nxt = skip - 3'd1;
          if (skip == 3'd1) d_nxt = NORMAL;
        end
        default: d_nxt = NORMAL;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c_st          <= BOSTA;
      bit_cnt       <= '0;
      shreg         <= '0;
      par           <= 1'b0;
      idle          <= '0;
      d_st          <= NORMAL;
      skip          <= '0;
      buton_giris   <= '0;
      buton_aktif   <= 1'b0;
      kontrol_giris <= '0;
      kontrol_aktif <= 1'b0;
      cerceve_hata  <= 1'b0;
    end else begin
      c_st          <= c_nxt;
      bit_cnt       <= bit_nxt;
      shreg         <= sh_nxt;
      par           <= par_nxt;
      idle          <= idle_nxt;
      d_st          <= d_nxt;
      skip          <= skip_nxt;
      buton_aktif   <= emit_but;
      kontrol_aktif <= emit_kon;
      cerceve_hata  <= hata_nxt;
      if (emit_but) buton_giris   <= shreg;
      if (emit_kon) kontrol_giris <= shreg;
    end
  end

endmodule

// File: tb/tb_ps2_tarama_alici.sv
// Bench for ps2_tarama_alici: drives PS/2 frames and checks every cycle against
// an event queue produced by a byte-level decoder model.
module tb_ps2_tarama_alici;

  localparam int F  = 4;
  localparam int ZA = 64;

  logic       clk = 1'b0, rst_n = 1'b1, ps2_clk = 1'b1, ps2_data = 1'b1;
  logic [7:0] buton_giris, kontrol_giris;
  logic       buton_aktif, kontrol_aktif, cerceve_hata;

  ps2_tarama_alici #(.FILTRE(F), .ZAMAN_ASIMI(ZA)) dut (
    .clk(clk), .rst_n(rst_n), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .buton_giris(buton_giris), .buton_aktif(buton_aktif),
    .kontrol_giris(kontrol_giris), .kontrol_aktif(kontrol_aktif),
    .cerceve_hata(cerceve_hata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {int t; int k; logic [7:0] v;} ev_t;  // k: 1 button, 2 control, 3 error
  ev_t q[$];

  int n_pass = 0, n_tot = 0;
  int n_but = 0, n_kon = 0, n_err = 0;
  int pause_left = 0;
  bit after_e0 = 0, skip_one = 0;
  logic [7:0] m_but = '0, m_kon = '0;
  int last_drop = 0;

  localparam logic [7:0] CTRL [0:22] = '{8'h58, 8'h12, 8'h59, 8'h77, 8'h29, 8'h76,
    8'h05, 8'h06, 8'h04, 8'h0C, 8'h03, 8'h0B, 8'h83, 8'h0A, 8'h01, 8'h09, 8'h78,
    8'h07, 8'h0D, 8'h14, 8'h11, 8'h66, 8'h5A};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
  endtask

  function automatic bit is_ctrl(input logic [7:0] b);
    for (int i = 0; i < 23; i++) if (CTRL[i] == b) return 1'b1;
    return 1'b0;
  endfunction

  // Byte-level reference: what a good byte produces on the channels.
  function automatic int model_byte(input logic [7:0] b);
    if (pause_left > 0) begin pause_left--; return 0; end
    if (skip_one) begin skip_one = 0; return 0; end
    if (b == 8'hF0) begin skip_one = 1; after_e0 = 0; return 0; end
    if (after_e0) begin
      after_e0 = 0;
      if (b == 8'h5A || b == 8'h14 || b == 8'h11) return 2;
      if (b == 8'h4A) return 1;
      return 0;
    end
    if (b == 8'hE0) begin after_e0 = 1; return 0; end
    if (b == 8'hE1) begin pause_left = 7; return 0; end
    if (b inside {8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFE, 8'hFF}) return 0;
    return is_ctrl(b) ? 2 : 1;
  endfunction

  // Sends the first nbits of a frame; only a complete frame queues an outcome,
  // due F+2 cycles after the stop-bit clock falls.
  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                            input int hp, input int stretch, input int nbits);
    logic [10:0] bits;
    int k;
    bits = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      ps2_data = bits[i];
      repeat ((i == stretch) ? (ZA - 1 - hp) : hp) @(negedge clk);
      ps2_clk = 1'b0;
      last_drop = cyc;
      if (i == 10) begin
        if (bad_par || bad_stop) q.push_back('{cyc + F + 2, 3, 8'h00});
        else begin
          k = model_byte(b);
          if (k != 0) q.push_back('{cyc + F + 2, k, b});
        end
      end
      repeat (hp) @(negedge clk);
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
  endtask

  task automatic good(input logic [7:0] b);
    send_frame(b, 1'b0, 1'b0, 8, -1, 11);
  endtask

  task automatic settle;
    repeat (12) @(negedge clk);
  endtask

  task automatic do_reset;
    @(negedge clk); #2 rst_n = 1'b0;
    q.delete();
    pause_left = 0; after_e0 = 0; skip_one = 0;
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  always @(negedge clk) begin
    int ek;
    logic [7:0] ev;
    if (!rst_n) begin
      chk("reset_outputs", {buton_giris, kontrol_giris, buton_aktif, kontrol_aktif, cerceve_hata}, 0);
      m_but = '0;
      m_kon = '0;
    end else begin
      ek = 0;
      ev = '0;
      while (q.size() > 0 && q[0].t < cyc) begin
        chk("event_missed_at", cyc, q[0].t);
        void'(q.pop_front());
      end
      if (q.size() > 0 && q[0].t == cyc) begin
        ek = q[0].k;
        ev = q[0].v;
        void'(q.pop_front());
      end
      if (ek == 1) m_but = ev;
      if (ek == 2) m_kon = ev;
      chk("strobes_but_kon_err", {buton_aktif, kontrol_aktif, cerceve_hata},
          (ek == 1) ? 3'b100 : (ek == 2) ? 3'b010 : (ek == 3) ? 3'b001 : 3'b000);
      chk("held_codes_but_kon", {buton_giris, kontrol_giris}, {m_but, m_kon});
      if (buton_aktif)   n_but++;
      if (kontrol_aktif) n_kon++;
      if (cerceve_hata)  n_err++;
    end
  end

  initial begin
    int b0, k0, e0;
    int r;
    logic [7:0] rb;
    #1 rst_n = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_buton_giris", buton_giris, 8'h00);
    chk("reset_kontrol_giris", kontrol_giris, 8'h00);

    b0 = n_but; k0 = n_kon; e0 = n_err;
    good(8'h1C); settle();
    chk("make_1C_code", buton_giris, 8'h1C);
    chk("make_1C_strobes", n_but - b0, 1);
    chk("make_1C_kontrol_untouched", kontrol_giris, 8'h00);

    b0 = n_but; k0 = n_kon;
    good(8'h58); good(8'hF0); good(8'h58); settle();
    chk("ctrl_58_code", kontrol_giris, 8'h58);
    chk("ctrl_58_one_strobe", n_kon - k0, 1);

    b0 = n_but; k0 = n_kon;
    good(8'hE0); good(8'h5A); good(8'hE0); good(8'hF0); good(8'h5A); settle();
    chk("ext_5A_code", kontrol_giris, 8'h5A);
    chk("ext_5A_one_strobe", n_kon - k0, 1);
    chk("ext_5A_no_button", n_but - b0, 0);

    b0 = n_but; e0 = n_err;
    send_frame(8'h1C, 1'b1, 1'b0, 8, -1, 11); settle();
    chk("parity_err_pulse", n_err - e0, 1);
    chk("parity_err_no_strobe", n_but - b0, 0);
    good(8'h1C); settle();
    chk("after_err_1C", n_but - b0, 1);

    k0 = n_kon; e0 = n_err;
    send_frame(8'h00, 1'b0, 1'b0, 8, -1, 4);
    q.push_back('{last_drop + F + 1 + ZA, 3, 8'h00});
    repeat (ZA + F + 10) @(negedge clk);
    chk("timeout_pulse", n_err - e0, 1);
    good(8'h5A); settle();
    chk("after_timeout_5A", n_kon - k0, 1);

    b0 = n_but; k0 = n_kon; e0 = n_err;
    good(8'hE1); good(8'h14); good(8'h77); good(8'hE1);
    good(8'hF0); good(8'h14); good(8'hF0); good(8'h77); settle();
    chk("pause_no_strobes", (n_but - b0) + (n_kon - k0) + (n_err - e0), 0);

    b0 = n_but; e0 = n_err;
    ps2_clk = 1'b0; repeat (F - 1) @(negedge clk); ps2_clk = 1'b1; repeat (10) @(negedge clk);
    ps2_clk = 1'b0; repeat (8) @(negedge clk); ps2_clk = 1'b1; repeat (10) @(negedge clk);
    good(8'h1C); settle();
    chk("glitch_then_1C", n_but - b0, 1);
    chk("glitch_no_error", n_err - e0, 0);

    k0 = n_kon; e0 = n_err;
    send_frame(8'h29, 1'b0, 1'b0, 8, 5, 11); settle();
    chk("edge_at_timeout_wins", n_err - e0, 0);
    chk("edge_at_timeout_code", kontrol_giris, 8'h29);

    send_frame(8'h16, 1'b0, 1'b0, 8, -1, 5);
    do_reset();
    chk("midframe_reset_outputs", {buton_giris, kontrol_giris}, 16'h0000);
    b0 = n_but; e0 = n_err;
    good(8'h16); settle();
    chk("after_reset_16", buton_giris, 8'h16);
    chk("after_reset_counts", {n_but - b0, n_err - e0}, {32'd1, 32'd0});

    for (int i = 0; i < 120; i++) begin
      r = $urandom_range(99, 0);
      if (r < 45)      rb = CTRL[$urandom_range(22, 0)];
      else if (r < 60) rb = (r < 52) ? 8'hF0 : (r < 58) ? 8'hE0 : 8'hE1;
      else if (r < 66) rb = 8'hFA;
      else             rb = 8'($urandom);
      r = $urandom_range(31, 0);
      send_frame(rb, r == 0 || r == 1, r == 2, $urandom_range(12, 6), -1, 11);
      repeat ($urandom_range(8, 0)) @(negedge clk);
    end
    settle();
    chk("queue_drained", q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
